seq_detect_scheduler: RTL and testbench

//   Shares one bit-serial 1101 sequence_detection instance among NREQ requesters.

---
 rtl/seq_detect_scheduler.sv | 223 ++++++++++++++++++++++
 tb/tb_seq_detect_scheduler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_scheduler.sv
// -----------------------------------------------------------------------------
// seq_detect_scheduler
//
// Shares one bit-serial "1101" sequence detector among NREQ requesters. For
// each accepted word the block picks a requester round-robin, pulses the
// detector clear, streams the word MSB-first onto det_a, counts det_z pulses
// inside the window where they can belong to this word, and returns
// {requester id, match count} on a valid/ready response port.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   req_valid  per-requester word pending (held until its req_ready)
//   req_word   requester i word at [i*WORD_W +: WORD_W]
//   req_ready  one-hot accept, combinational, only while idle
//   det_clear  one-cycle clear pulse to the detector
//   det_a      serial bit to detector input A
//   det_z      detector output Z
//   rsp_valid  response available
//   rsp_id     index of the served requester
//   rsp_count  saturating count of det_z pulses for the word
//   rsp_ready  consumer accepts the response
//   busy       high whenever the scheduler is not idle
// -----------------------------------------------------------------------------
module seq_detect_scheduler #(
    parameter int NREQ    = 4,
    parameter int WORD_W  = 8,
    parameter int DET_LAT = 1,
    parameter int CNT_W   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*WORD_W-1:0]   req_word,
    output logic [NREQ-1:0]          req_ready,
    output logic                     det_clear,
    output logic                     det_a,
    input  logic                     det_z,
    output logic                     rsp_valid,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [CNT_W-1:0]         rsp_count,
    input  logic                     rsp_ready,
    output logic                     busy
);

    localparam int ID_W = $clog2(NREQ);
    // k runs 0 .. WORD_W-1+DET_LAT and is incremented once past the end
    localparam int K_W  = $clog2(WORD_W + DET_LAT + 1);

    localparam logic [K_W-1:0]   K_LAST_SHIFT   = K_W'(WORD_W - 1);
    localparam logic [K_W-1:0]   K_LAST         = K_W'(WORD_W - 1 + DET_LAT);
    localparam logic [K_W-1:0]   K_FIRST_SAMPLE = K_W'(DET_LAT);
    localparam logic [CNT_W-1:0] CNT_MAX        = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DRAIN = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    state_t             state_r;
    logic [ID_W-1:0]    last_grant_r;
    logic [ID_W-1:0]    id_r;
    logic [WORD_W-1:0]  shift_r;
    logic [K_W-1:0]     k_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               det_clear_r;
    logic               det_a_r;
    logic               rsp_valid_r;
    logic [ID_W-1:0]    rsp_id_r;
    logic [CNT_W-1:0]   rsp_count_r;
    logic               busy_r;

    logic               grant_found_s;
    logic [ID_W-1:0]    grant_idx_s;
    logic [ID_W-1:0]    cand_s;
    logic               take_s;
    logic [NREQ-1:0]    req_ready_s;
    logic               sample_s;
    logic [CNT_W-1:0]   cnt_next_s;

    // Saturating increment of the match counter
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    // Round-robin search: first valid requester at or after last_grant+1
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        cand_s        = '0;
        take_s        = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            cand_s        = ID_W'((int'(last_grant_r) + 1 + j) % NREQ);
            take_s        = !grant_found_s && req_valid[cand_s];
            grant_idx_s   = take_s ? cand_s : grant_idx_s;
            grant_found_s = grant_found_s | take_s;
        end
    end

    // One-hot accept, only while idle and never while reset is asserted
    always_comb begin
        req_ready_s = '0;
        if ((state_r == ST_IDLE) && !reset && grant_found_s) begin
            req_ready_s = {{(NREQ-1){1'b0}}, 1'b1} << grant_idx_s;
        end else begin
            req_ready_s = '0;
        end
    end

    // det_z counts only in k = DET_LAT .. WORD_W-1+DET_LAT of SHIFT/DRAIN
    always_comb begin
        sample_s   = ((state_r == ST_SHIFT) || (state_r == ST_DRAIN)) &&
                     (k_r >= K_FIRST_SAMPLE) && det_z;
        cnt_next_s = cnt_r;
        if (sample_s) begin
            cnt_next_s = sat_inc(cnt_r);
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Scheduler FSM with registered detector and response outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            last_grant_r <= ID_W'(NREQ - 1);  // requester 0 wins first
            id_r         <= '0;
            shift_r      <= '0;
            k_r          <= '0;
            cnt_r        <= '0;
            det_clear_r  <= 1'b0;
            det_a_r      <= 1'b0;
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= '0;
            rsp_count_r  <= '0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_found_s) begin
                        shift_r     <= req_word[grant_idx_s*WORD_W +: WORD_W];
                        id_r        <= grant_idx_s;
                        det_clear_r <= 1'b1;
                        busy_r      <= 1'b1;
                        state_r     <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    // det_a is registered, so the MSB is launched here to be
                    // on the wire during the first SHIFT cycle
                    det_clear_r <= 1'b0;
                    det_a_r     <= shift_r[WORD_W-1];
                    shift_r     <= {shift_r[WORD_W-2:0], 1'b0};
                    k_r         <= '0;
                    cnt_r       <= '0;
                    state_r     <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    k_r   <= k_r + K_W'(1);
                    cnt_r <= cnt_next_s;
                    if (k_r == K_LAST_SHIFT) begin
                        det_a_r <= 1'b0;
                        if (DET_LAT == 0) begin
                            rsp_valid_r <= 1'b1;
                            rsp_id_r    <= id_r;
                            rsp_count_r <= cnt_next_s;
                            state_r     <= ST_RESP;
                        end else begin
                            state_r     <= ST_DRAIN;
                        end
                    end else begin
                        det_a_r <= shift_r[WORD_W-1];
                        shift_r <= {shift_r[WORD_W-2:0], 1'b0};
                    end
                end
                ST_DRAIN: begin
                    // Wait for Z pulses caused by the last bits of the word
                    k_r   <= k_r + K_W'(1);
                    cnt_r <= cnt_next_s;
                    if (k_r == K_LAST) begin
                        rsp_valid_r <= 1'b1;
                        rsp_id_r    <= id_r;
                        rsp_count_r <= cnt_next_s;
                        state_r     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r  <= 1'b0;
                        rsp_id_r     <= '0;
                        rsp_count_r  <= '0;
                        last_grant_r <= id_r;
                        busy_r       <= 1'b0;
                        state_r      <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    det_clear_r <= 1'b0;
                    det_a_r     <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_s;
    assign det_clear = det_clear_r;
    assign det_a     = det_a_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_count = rsp_count_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_scheduler
//
// Drives two scheduler instances in lockstep (CNT_W=4 and CNT_W=1), each
// attached to its own behavioural non-overlapping 1101 detector with one
// cycle of output latency. A transaction-level reference (round-robin
// pointer, job timeline, greedy pattern count) predicts every output cycle
// by cycle. Directed sequences come first, then randomized traffic.
// -----------------------------------------------------------------------------
module tb_seq_detect_scheduler;

    localparam int NREQ    = 4;
    localparam int WORD_W  = 8;
    localparam int DET_LAT = 1;
    localparam int CNT_W   = 4;
    localparam int RSP_OFF = 2 + WORD_W + DET_LAT;   // grant -> rsp_valid
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ*WORD_W-1:0]  req_word;
    logic                    rsp_ready;

    logic [NREQ-1:0]         req_ready,   s_req_ready;
    logic                    det_clear,   s_det_clear;
    logic                    det_a,       s_det_a;
    logic                    det_z,       s_det_z;
    logic                    rsp_valid,   s_rsp_valid;
    logic [1:0]              rsp_id,      s_rsp_id;
    logic [CNT_W-1:0]        rsp_count;
    logic [0:0]              s_rsp_count;
    logic                    busy,        s_busy;

    seq_detect_scheduler #(.NREQ(NREQ), .WORD_W(WORD_W), .DET_LAT(DET_LAT), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_word(req_word),
        .req_ready(req_ready), .det_clear(det_clear), .det_a(det_a), .det_z(det_z),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_count(rsp_count),
        .rsp_ready(rsp_ready), .busy(busy)
    );

    seq_detect_scheduler #(.NREQ(NREQ), .WORD_W(WORD_W), .DET_LAT(DET_LAT), .CNT_W(1)) u_sat (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_word(req_word),
        .req_ready(s_req_ready), .det_clear(s_det_clear), .det_a(s_det_a), .det_z(s_det_z),
        .rsp_valid(s_rsp_valid), .rsp_id(s_rsp_id), .rsp_count(s_rsp_count),
        .rsp_ready(rsp_ready), .busy(s_busy)
    );

    always #5 clk = ~clk;

    // Behavioural detectors: last three bits plus run length since restart
    logic [2:0] dh [2];
    int         dr [2];
    logic       dz [2];
    logic       da [2];
    logic       dc [2];
    assign da[0] = det_a;     assign dc[0] = det_clear;
    assign da[1] = s_det_a;   assign dc[1] = s_det_clear;
    assign det_z   = dz[0];
    assign s_det_z = dz[1];

    always @(posedge clk or posedge reset) begin
        for (int d = 0; d < 2; d++) begin
            if (reset || dc[d]) begin
                dh[d] <= 3'b000; dr[d] <= 0; dz[d] <= 1'b0;
            end else if (dr[d] >= 3 && {dh[d], da[d]} == 4'b1101) begin
                dh[d] <= 3'b000; dr[d] <= 0; dz[d] <= 1'b1;
            end else begin
                dh[d] <= {dh[d][1:0], da[d]};
                dr[d] <= (dr[d] >= 3) ? 3 : dr[d] + 1;
                dz[d] <= 1'b0;
            end
        end
    end

    // Reference state
    int                 n_cmp = 0;
    int                 n_bad = 0;
    int                 cyc = 0;
    int                 last_g_m;
    bit                 job_active;
    int                 job_gcycle;
    int                 job_id;
    logic [WORD_W-1:0]  job_word;
    logic [NREQ-1:0]    pend_v;
    logic [WORD_W-1:0]  pend_w [NREQ];
    logic               rsp_rdy_drv;
    logic               rst_drv;
    int                 glog [$];

    // Greedy left-to-right count of non-overlapping 1101 in a word
    function automatic int count1101(input logic [WORD_W-1:0] w);
        int n = 0;
        int p = WORD_W - 1;
        while (p >= 3) begin
            if (w[p -: 4] == 4'b1101) begin
                n++; p -= 4;
            end else begin
                p--;
            end
        end
        return n;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // One clock: drive at negedge, check #1 later, advance the reference
    task automatic step();
        int              exp_g;
        int              off;
        int              n;
        bit              exp_rv;
        logic [NREQ-1:0] exp_rdy;
        @(negedge clk);
        reset     = rst_drv;
        req_valid = pend_v;
        for (int i = 0; i < NREQ; i++) req_word[i*WORD_W +: WORD_W] = pend_w[i];
        rsp_ready = rsp_rdy_drv;
        #1;
        if (rst_drv) begin
            check_val("rst_outs", {req_ready, det_clear, det_a, rsp_valid, rsp_id, rsp_count, busy}, 32'd0);
            check_val("rst_outs_sat", {s_req_ready, s_det_clear, s_det_a, s_rsp_valid, s_rsp_id, s_rsp_count, s_busy}, 32'd0);
            job_active = 1'b0;
            last_g_m   = NREQ - 1;
        end else begin
            exp_g = -1;
            if (!job_active) begin
                for (int j = 0; j < NREQ; j++) begin
                    int c;
                    c = (last_g_m + 1 + j) % NREQ;
                    if (exp_g < 0 && pend_v[c]) exp_g = c;
                end
            end
            exp_rdy = '0;
            if (exp_g >= 0) exp_rdy[exp_g] = 1'b1;
            check_val("req_ready", req_ready, exp_rdy);
            for (int j = 0; j < NREQ; j++) if (req_ready[j]) glog.push_back(j);

            off = cyc - job_gcycle;
            check_val("busy", busy, job_active && off > 0);
            check_val("det_clear", det_clear, job_active && off == 1);
            if (job_active && off >= 1 && off <= RSP_OFF - 1)
                check_val("det_a", det_a, (off >= 2 && off <= WORD_W + 1) ? job_word[WORD_W + 1 - off] : 1'b0);
            exp_rv = job_active && off >= RSP_OFF;
            check_val("rsp_valid", rsp_valid, exp_rv);
            check_val("sat_rsp_valid", s_rsp_valid, exp_rv);
            if (exp_rv) begin
                n = count1101(job_word);
                check_val("rsp_id", rsp_id, job_id);
                check_val("rsp_count", rsp_count, (n > CMAX) ? CMAX : n);
                check_val("sat_rsp_count", s_rsp_count, (n > 1) ? 1 : n);
                if (rsp_rdy_drv) begin
                    job_active = 1'b0;
                    last_g_m   = job_id;
                end
            end
            if (exp_g >= 0) begin
                job_active     = 1'b1;
                job_gcycle     = cyc;
                job_id         = exp_g;
                job_word       = pend_w[exp_g];
                pend_v[exp_g]  = 1'b0;
            end
        end
        cyc++;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 80 && (job_active || pend_v != '0); t++) step();
        check_val("drain_done", {31'd0, job_active || (pend_v != '0)}, 32'd0);
    endtask

    initial begin
        int exp3 [6] = '{0, 1, 2, 3, 0, 2};
        rst_drv = 1'b1; reset = 1'b1;
        req_valid = '0; req_word = '0; rsp_ready = 1'b0;
        pend_v = '0; rsp_rdy_drv = 1'b1;
        for (int i = 0; i < NREQ; i++) pend_w[i] = '0;
        job_active = 1'b0; job_gcycle = 0; job_id = 0; job_word = '0;
        last_g_m = NREQ - 1;

        // Reset with a request already pending: nothing may be accepted
        pend_v = 4'b0100; pend_w[2] = 8'hDD;
        step(); step();
        pend_v = '0;
        rst_drv = 1'b0;
        step();

        // Round-robin order from the reset pointer, then a sparse pattern
        glog.delete();
        pend_v = 4'b1111;
        pend_w[0] = 8'h3D; pend_w[1] = 8'hD1; pend_w[2] = 8'h0D; pend_w[3] = 8'hDD;
        wait_idle();
        pend_v = 4'b0101; pend_w[0] = 8'hB4; pend_w[2] = 8'h6D;
        wait_idle();
        check_val("grant_cnt", glog.size(), 6);
        for (int k = 0; k < 6; k++)
            if (k < glog.size()) check_val("grant_order", glog[k], exp3[k]);

        // Two matches in one word, then words that must not see stale state
        pend_v = 4'b0001; pend_w[0] = 8'b1101_1101; wait_idle();
        pend_v = 4'b0010; pend_w[1] = 8'b0000_0110; wait_idle();
        pend_v = 4'b0010; pend_w[1] = 8'b1000_0000; wait_idle();
        pend_v = 4'b0001; pend_w[0] = 8'hFF;        wait_idle();

        // Consumer stalls in RESP while another requester waits
        rsp_rdy_drv = 1'b0;
        pend_v = 4'b0100; pend_w[2] = 8'hD0;
        step();
        for (int t = 0; t < RSP_OFF - 1; t++) step();
        pend_v[3] = 1'b1; pend_w[3] = 8'h1B;
        for (int t = 0; t < 6; t++) step();
        rsp_rdy_drv = 1'b1;
        wait_idle();
        pend_v = 4'b0100; pend_w[2] = 8'h5A; wait_idle();

        // Reset in the fourth SHIFT cycle aborts the job and the pointer
        pend_v = 4'b0010; pend_w[1] = 8'hB6;
        for (int t = 0; t < 30 && !(job_active && cyc - job_gcycle == 5); t++) step();
        check_val("reach_shift4", {31'd0, job_active && (cyc - job_gcycle == 5)}, 32'd1);
        rst_drv = 1'b1;
        pend_v = 4'b1001; pend_w[0] = 8'hDD; pend_w[3] = 8'hD3;
        step();
        rst_drv = 1'b0;
        glog.delete();
        wait_idle();
        check_val("post_rst_grant", (glog.size() > 0) ? glog[0] : 99, 32'd0);

        // Randomized traffic, drops before grant, random consumer stalls
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend_v[i] && $urandom_range(3) == 0) begin
                    pend_v[i] = 1'b1;
                    pend_w[i] = 8'($urandom);
                    if ($urandom_range(1) == 0) pend_w[i][7:4] = 4'b1101;
                end else if (pend_v[i] && $urandom_range(15) == 0) begin
                    pend_v[i] = 1'b0;
                end
            end
            rsp_rdy_drv = ($urandom_range(3) != 0);
            step();
        end
        pend_v = '0;
        rsp_rdy_drv = 1'b1;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
